reg_writeback_queue: RTL and testbench
======================================

Name: reg_writeback_queue

Overview:
- Write-side companion of the 32x32 register file. Collects register write requests from the execute/memory stages and buffers them in a small FIFO.
- Drains one write per cycle into the register file write port (RegWrite/WriteReg/WriteData) unless stalled.
- Provides two combinational forwarding lookups so readers see pending writes the register file does not yet hold.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >= 2)
- ADDR_W, 5, register index width
- DATA_W, 32, register data width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  write request present
- in_ready  output  1  queue can accept a request this cycle
- in_reg  input  ADDR_W  destination register index
- in_data  input  DATA_W  value to write
- wb_stall  input  1  hold the drain; no write issued while high
- RegWrite  output  1  write strobe to register file, registered
- WriteReg  output  ADDR_W  write index to register file, registered
- WriteData  output  DATA_W  write data to register file, registered
- ReadReg1  input  ADDR_W  forwarding lookup index, port 1
- ReadReg2  input  ADDR_W  forwarding lookup index, port 2
- fwd_hit1  output  1  a pending write to ReadReg1 exists
- fwd_data1  output  DATA_W  data of that pending write
- fwd_hit2  output  1  a pending write to ReadReg2 exists
- fwd_data2  output  DATA_W  data of that pending write
- count  output  clog2(DEPTH)+1  entries currently in the FIFO (output stage excluded)

Behaviour:
- Reset (rst high at a clk edge): count=0; RegWrite=0; WriteReg=0; WriteData=0; all entries invalid. in_ready=1 and fwd_hit*=0 the cycle after. Any queued or in-flight write is discarded, including on reset mid-drain.
- in_ready = (count < DEPTH), combinational from state only. It does not depend on in_valid or on a same-cycle pop.
- Accept: in_valid && in_ready at an edge.
- Accepted write with in_reg==0 is dropped: no entry allocated, no RegWrite, count unchanged.
- Drain, evaluated each edge with rst low:
  - If wb_stall=1: RegWrite<=0, and WriteReg/WriteData hold their values.
  - Else if count>0: pop head into WriteReg/WriteData, RegWrite<=1.
  - Else if accept of a nonzero in_reg this cycle: flow-through. The request goes directly to the output registers with RegWrite<=1 and count unchanged.
  - Else: RegWrite<=0.
- Latency: request accepted at edge N into an empty, unstalled queue gives RegWrite=1 during cycle N+1. Each queued entry adds one cycle.
- Push and pop in the same cycle: count unchanged. The new entry goes to the tail; FIFO order is strictly preserved.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- RegWrite is high for exactly one cycle per drained write. Back-to-back drains give consecutive high cycles.
- Forwarding (combinational, per port): search the valid FIFO entries plus the output stage (when RegWrite=1) for index == ReadRegX.
  - Priority: youngest FIFO entry > older FIFO entries > output stage.
  - Index 0 never hits.
  - A same-cycle incoming request is not forwarded.
  - On a miss, fwd_dataX=0.

Optional Feature:
- Macro WB_COALESCE_EN.
- Defined: an accepted request whose in_reg matches a valid FIFO entry overwrites that entry's data in place (youngest match only). No new entry is allocated, count is unchanged, and order is kept. in_ready is still count<DEPTH. The output stage is never coalesced.
- Undefined: every accepted nonzero request allocates a new entry.

Test Plan:
- Reset then single write: rst 1 cycle; in_reg=8, in_data=10 at edge N -> RegWrite=1, WriteReg=8, WriteData=10 in cycle N+1; RegWrite=0 in N+2; count=0 throughout.
- Fill under stall: wb_stall=1; push regs 9,10,11,12 with data 20,22,40,50 -> count=4, in_ready=0, RegWrite=0. Release stall -> four consecutive RegWrite pulses in order 9,10,11,12; in_ready=1 after the first pop.
- Zero register: push in_reg=0, data=99 -> in_ready=1, count stays 0, RegWrite never asserts, fwd_hit=0 for ReadReg1=0.
- Forwarding priority: stall, push reg16=1 then reg16=7 (WB_COALESCE_EN undefined) -> ReadReg1=16 gives fwd_hit1=1, fwd_data1=7; ReadReg2=17 gives fwd_hit2=0, fwd_data2=0.
- Coalescing: with WB_COALESCE_EN defined, stall, push reg16=1 then reg16=7 -> count=1; on release a single RegWrite with WriteReg=16, WriteData=7.
- Reset mid-drain: 3 entries queued, assert rst while RegWrite=1 -> next cycle RegWrite=0, count=0, no further writes after rst drops.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// Write-back queue in front of the 32x32 register file: buffers write requests, drains one per cycle,
// and forwards pending writes to two readers. Optional in-place coalescing is enabled by WB_COALESCE_EN.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  // Request side: a request transfers on any edge where in_valid && in_ready.
  // in_ready depends only on stored state, never on in_valid or a same-cycle pop.
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wb_stall,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        ReadReg1,
  input  logic [ADDR_W-1:0]        ReadReg2,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              regwrite_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              req_nz;
  logic              pop;
  logic              flow;
  logic              push_alloc;
  logic              coalesce;
  logic              co_hit;
  logic [PTR_W-1:0]  co_slot;

  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign req_nz   = (in_reg != '0);
  assign pop      = !wb_stall && (count_q != '0);
  assign flow     = !wb_stall && (count_q == '0) && accept && req_nz;

  // Youngest valid entry with the incoming index; the head being popped
  // this cycle is leaving for the output stage and is not a target.
  always_comb begin
    logic [PTR_W-1:0] slot;
    co_hit  = 1'b0;
    co_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if (valid_q[slot] && (ent_reg_q[slot] == in_reg) && !(pop && (slot == head_q))) begin
        co_hit  = 1'b1;
        co_slot = slot;
      end
    end
  end

`ifdef WB_COALESCE_EN
  assign coalesce   = accept && req_nz && !flow && co_hit;
`else
  assign coalesce   = 1'b0;
`endif
  assign push_alloc = accept && req_nz && !flow && !coalesce;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push_alloc) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push_alloc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
      end
      // Full queue never accepts, so the tail slot can never be the head being popped.
      if (push_alloc) begin
        valid_q[tail_q]    <= 1'b1;
        ent_reg_q[tail_q]  <= in_reg;
        ent_data_q[tail_q] <= in_data;
      end
      if (coalesce) begin
        ent_data_q[co_slot] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else if (wb_stall) begin
      regwrite_q <= 1'b0;
    end else if (pop) begin
      regwrite_q <= 1'b1;
      wreg_q     <= ent_reg_q[head_q];
      wdata_q    <= ent_data_q[head_q];
    end else if (flow) begin
      regwrite_q <= 1'b1;
      wreg_q     <= in_reg;
      wdata_q    <= in_data;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  // Scan oldest to youngest so later matches override; the output stage is lowest priority.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] idx);
    logic [DATA_W:0]  r;
    logic [PTR_W-1:0] slot;
    r = '0;
    if (idx != '0) begin
      if (regwrite_q && (wreg_q == idx)) begin
        r = {1'b1, wdata_q};
      end
      for (int k = 0; k < DEPTH; k++) begin
        slot = head_q + PTR_W'(k);
        if (valid_q[slot] && (ent_reg_q[slot] == idx)) begin
          r = {1'b1, ent_data_q[slot]};
        end
      end
    end
    return r;
  endfunction

  logic [DATA_W:0] fwd1, fwd2;

  always_comb begin
    fwd1 = fwd_lookup(ReadReg1);
    fwd2 = fwd_lookup(ReadReg2);
  end

  assign fwd_hit1  = fwd1[DATA_W];
  assign fwd_data1 = fwd1[DATA_W-1:0];
  assign fwd_hit2  = fwd2[DATA_W];
  assign fwd_data2 = fwd2[DATA_W-1:0];

  assign RegWrite  = regwrite_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign count     = count_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue; define WB_COALESCE_EN to exercise coalescing instead of forwarding priority.
module tb_reg_writeback_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        wb_stall;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  reg_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_stall(wb_stall),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ReadReg1 = 5'd8;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
    total++; if (WriteReg !== 5'd0 || WriteData !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%0d/%0d exp=0/0", WriteReg, WriteData); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    total++; if (fwd_hit1 !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b exp=0", fwd_hit1); end
  endtask

  task automatic test_single();
    push(5'd8, 32'd10);
    ReadReg1 = 5'd8;
    #1;
    total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd8 || WriteData !== 32'd10) begin
      bad++; $display("FAIL single_out got=%b/%0d/%0d exp=1/8/10", RegWrite, WriteReg, WriteData); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", count); end
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd10) begin
      bad++; $display("FAIL single_fwd_outstage got=%b/%0d exp=1/10", fwd_hit1, fwd_data1); end
    tick();
    total++; if (RegWrite !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL single_after got=%b/%0d exp=0/0", RegWrite, count); end
  endtask

  task automatic test_fill_stall();
    logic [4:0]  regs [4];
    logic [31:0] datas [4];
    regs  = '{5'd9, 5'd10, 5'd11, 5'd12};
    datas = '{32'd20, 32'd22, 32'd40, 32'd50};
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(regs[i], datas[i]);
    ReadReg1 = 5'd11;
    #1;
    total++; if (count !== 3'd4 || in_ready !== 1'b0 || RegWrite !== 1'b0) begin
      bad++; $display("FAIL fill_state got=%0d/%b/%b exp=4/0/0", count, in_ready, RegWrite); end
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd40) begin
      bad++; $display("FAIL fill_fwd got=%b/%0d exp=1/40", fwd_hit1, fwd_data1); end
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (RegWrite !== 1'b1 || WriteReg !== regs[i] || WriteData !== datas[i] || count !== 3'(3 - i)) begin
        bad++; $display("FAIL drain_%0d got=%b/%0d/%0d cnt=%0d exp=1/%0d/%0d cnt=%0d",
                        i, RegWrite, WriteReg, WriteData, count, regs[i], datas[i], 3 - i); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_%0d got=%b exp=1", i, in_ready); end
    end
    tick();
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL drain_end got=%b exp=0", RegWrite); end
  endtask

  task automatic test_zero_reg();
    in_valid = 1'b1;
    in_reg   = 5'd0;
    in_data  = 32'd99;
    ReadReg1 = 5'd0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (count !== 3'd0 || RegWrite !== 1'b0) begin
      bad++; $display("FAIL zero_push got=%0d/%b exp=0/0", count, RegWrite); end
    total++; if (fwd_hit1 !== 1'b0) begin bad++; $display("FAIL zero_fwd got=%b exp=0", fwd_hit1); end
    tick();
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL zero_later got=%b exp=0", RegWrite); end
  endtask

  task automatic test_back_to_back();
    wb_stall = 1'b1;
    push(5'd3, 32'd30);
    push(5'd4, 32'd40);
    wb_stall = 1'b0;
    push(5'd5, 32'd50);
    total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'd30 || count !== 3'd2) begin
      bad++; $display("FAIL b2b_0 got=%b/%0d/%0d cnt=%0d exp=1/3/30 cnt=2", RegWrite, WriteReg, WriteData, count); end
    tick();
    total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd4 || WriteData !== 32'd40 || count !== 3'd1) begin
      bad++; $display("FAIL b2b_1 got=%b/%0d/%0d cnt=%0d exp=1/4/40 cnt=1", RegWrite, WriteReg, WriteData, count); end
    tick();
    total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'd50 || count !== 3'd0) begin
      bad++; $display("FAIL b2b_2 got=%b/%0d/%0d cnt=%0d exp=1/5/50 cnt=0", RegWrite, WriteReg, WriteData, count); end
    tick();
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", RegWrite); end
  endtask

`ifdef WB_COALESCE_EN
  task automatic test_coalesce();
    wb_stall = 1'b1;
    push(5'd16, 32'd1);
    push(5'd16, 32'd7);
    ReadReg1 = 5'd16;
    #1;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL coal_count got=%0d exp=1", count); end
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd7) begin
      bad++; $display("FAIL coal_fwd got=%b/%0d exp=1/7", fwd_hit1, fwd_data1); end
    wb_stall = 1'b0;
    tick();
    total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd16 || WriteData !== 32'd7 || count !== 3'd0) begin
      bad++; $display("FAIL coal_out got=%b/%0d/%0d cnt=%0d exp=1/16/7 cnt=0", RegWrite, WriteReg, WriteData, count); end
    tick();
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL coal_single got=%b exp=0", RegWrite); end
  endtask
`else
  task automatic test_fwd_priority();
    wb_stall = 1'b1;
    push(5'd16, 32'd1);
    push(5'd16, 32'd7);
    ReadReg1 = 5'd16;
    ReadReg2 = 5'd17;
    #1;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL fwd_count got=%0d exp=2", count); end
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd7) begin
      bad++; $display("FAIL fwd_youngest got=%b/%0d exp=1/7", fwd_hit1, fwd_data1); end
    total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin
      bad++; $display("FAIL fwd_miss got=%b/%0d exp=0/0", fwd_hit2, fwd_data2); end
    in_valid = 1'b1;
    in_reg   = 5'd17;
    in_data  = 32'd5;
    #1;
    total++; if (fwd_hit2 !== 1'b0) begin bad++; $display("FAIL fwd_incoming got=%b exp=0", fwd_hit2); end
    in_valid = 1'b0;
    wb_stall = 1'b0;
    tick();
    total++; if (RegWrite !== 1'b1 || WriteData !== 32'd1 || fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd7) begin
      bad++; $display("FAIL fwd_fifo_over_out got=%b/%0d fwd=%b/%0d exp=1/1 fwd=1/7", RegWrite, WriteData, fwd_hit1, fwd_data1); end
    tick();
    total++; if (RegWrite !== 1'b1 || WriteData !== 32'd7 || fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd7) begin
      bad++; $display("FAIL fwd_outstage got=%b/%0d fwd=%b/%0d exp=1/7 fwd=1/7", RegWrite, WriteData, fwd_hit1, fwd_data1); end
    tick();
    total++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0 || RegWrite !== 1'b0) begin
      bad++; $display("FAIL fwd_drained got=%b/%0d rw=%b exp=0/0 rw=0", fwd_hit1, fwd_data1, RegWrite); end
  endtask
`endif

  task automatic test_reset_mid_drain();
    wb_stall = 1'b1;
    push(5'd1, 32'd11);
    push(5'd2, 32'd12);
    push(5'd3, 32'd13);
    wb_stall = 1'b0;
    tick();
    total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd1 || count !== 3'd2) begin
      bad++; $display("FAIL mid_pre got=%b/%0d cnt=%0d exp=1/1 cnt=2", RegWrite, WriteReg, count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (RegWrite !== 1'b0 || count !== 3'd0 || WriteReg !== 5'd0 || WriteData !== 32'd0) begin
      bad++; $display("FAIL mid_rst got=%b/%0d/%0d cnt=%0d exp=0/0/0 cnt=0", RegWrite, WriteReg, WriteData, count); end
    ReadReg1 = 5'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (RegWrite !== 1'b0 || count !== 3'd0 || fwd_hit1 !== 1'b0) begin
        bad++; $display("FAIL mid_after_%0d got=%b cnt=%0d fwd=%b exp=0 cnt=0 fwd=0", i, RegWrite, count, fwd_hit1); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    wb_stall = 1'b0;
    ReadReg1 = '0;
    ReadReg2 = '0;
    test_reset();
    test_single();
    test_fill_stall();
    test_zero_reg();
    test_back_to_back();
`ifdef WB_COALESCE_EN
    test_coalesce();
`else
    test_fwd_priority();
`endif
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
